// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: single-owner arbiter sharing the 64x1024x8 SRAM array between the host port and BIST.
// Ports: CLK/RSTN (async active-low); H_* host request/grant/read-data handshake;
// BIST_REQ/BIST_EN ownership handoff, BIST_PASS/NEED_REPAIR_* sampled on BIST exit -> BIST_RESULT/REPAIR_ACTIVE;
// MEM_* registered array strobes (idle values whenever the host is not accessing), MEM_ODATA array read data.
// Build option REPAIR_REMAP_EN: host accesses hitting the active repair entry go to an internal spare byte.
module mem_access_arbiter #(
    parameter int NBANK = 64,
    parameter int SEL_W = 6,
    parameter int AW    = 10,
    parameter int DW    = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             H_REQ,
    input  logic             H_WE,
    input  logic [15:0]      H_ADDR,
    input  logic [DW-1:0]    H_WDATA,
    output logic             H_GNT,
    output logic             H_RVALID,
    output logic [DW-1:0]    H_RDATA,
    output logic             H_BUSY,
    input  logic             BIST_REQ,
    output logic             BIST_EN,
    input  logic             BIST_PASS,
    input  logic [AW-1:0]    NEED_REPAIR_ADDR,
    input  logic [SEL_W-1:0] NEED_REPAIR_SELECT,
    output logic             BIST_RESULT,
    output logic             REPAIR_ACTIVE,
    output logic [AW-1:0]    MEM_ADDR,
    output logic             MEM_CE,
    output logic             MEM_WEB,
    output logic [NBANK-1:0] MEM_OEB,
    output logic [NBANK-1:0] MEM_CSB,
    output logic [DW-1:0]    MEM_IDATA,
    output logic [SEL_W-1:0] MEM_ODATA_SELECT,
    input  logic [DW-1:0]    MEM_ODATA
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_BIST = 2'd3;

    logic [1:0]          state, nxt;
    logic                we_q, n_we, cap, act, n_hit;
    logic [15:0]         addr_q, n_addr;
    logic [DW-1:0]       wdata_q, n_wdata, rd;
    logic [SEL_W-1:0]    s;
    logic [NBANK-1:0]    oh;
    logic [SEL_W+AW-1:0] rep_q;

    // BIST has priority over a host request seen in the same IDLE cycle
    assign cap     = state == S_IDLE && !BIST_REQ && H_REQ;
    assign nxt     = state == S_IDLE ? (BIST_REQ ? S_BIST : H_REQ ? S_ACC : S_IDLE) :
                     state == S_ACC  ? (we_q ? S_IDLE : S_CAP) :
                     (state == S_BIST && BIST_REQ) ? S_BIST : S_IDLE;
    assign n_we    = cap ? H_WE : we_q;
    assign n_addr  = cap ? H_ADDR : addr_q;
    assign n_wdata = cap ? H_WDATA : wdata_q;
    assign s       = n_addr[AW +: SEL_W];
    assign oh      = {{(NBANK-1){1'b0}}, 1'b1} << s;
    // strobes are registered from the next state so they line up with ACC/CAP
    assign act     = (nxt == S_ACC || nxt == S_CAP) && !n_hit;
    assign H_GNT   = state == S_ACC;
    assign H_BUSY  = state != S_IDLE;
    assign BIST_EN = state == S_BIST;

`ifdef REPAIR_REMAP_EN
    logic          hit_q;
    logic [DW-1:0] spare;
    assign n_hit = REPAIR_ACTIVE && n_addr[SEL_W+AW-1:0] == rep_q;
    assign rd    = hit_q ? spare : MEM_ODATA;
    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) begin
            hit_q <= 1'b0;
            spare <= '0;
        end else begin
            hit_q <= n_hit;
            if (state == S_ACC && we_q && hit_q) spare <= wdata_q;
        end
`else
    assign n_hit = 1'b0;
    assign rd    = MEM_ODATA;
`endif

    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) begin
            state            <= S_IDLE;
            we_q             <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            H_RVALID         <= 1'b0;
            H_RDATA          <= '0;
            BIST_RESULT      <= 1'b0;
            REPAIR_ACTIVE    <= 1'b0;
            rep_q            <= '0;
            MEM_CE           <= 1'b0;
            MEM_WEB          <= 1'b1;
            MEM_ADDR         <= '0;
            MEM_CSB          <= '1;
            MEM_OEB          <= '1;
            MEM_IDATA        <= '0;
            MEM_ODATA_SELECT <= '0;
        end else begin
            state            <= nxt;
            we_q             <= n_we;
            addr_q           <= n_addr;
            wdata_q          <= n_wdata;
            H_RVALID         <= state == S_CAP;
            if (state == S_CAP) H_RDATA <= rd;
            if (state == S_BIST && !BIST_REQ) begin
                BIST_RESULT   <= BIST_PASS;
                REPAIR_ACTIVE <= !BIST_PASS;
                if (!BIST_PASS) rep_q <= {NEED_REPAIR_SELECT, NEED_REPAIR_ADDR};
            end
            MEM_CE           <= act;
            MEM_WEB          <= !(act && n_we);
            MEM_ADDR         <= act ? n_addr[AW-1:0] : '0;
            MEM_CSB          <= act ? ~oh : '1;
            MEM_OEB          <= (act && !n_we) ? ~oh : '1;
            MEM_IDATA        <= (act && n_we) ? n_wdata : '0;
            MEM_ODATA_SELECT <= act ? s : '0;
        end
endmodule
